// File: rtl/data_mem_bist_pkg.sv
// rtl/data_mem_bist_pkg.sv - shared types and constants for the Data_Memory march-test BIST
//
// Purpose : state encoding, geometry of the tested memory and the default
//           background pattern, plus a saturating counter helper.
// Ports   : none (package).
package data_mem_bist_pkg;

   // Test sequencer states. The state names the phase whose bus cycle is
   // currently presented to the memory, because all bus outputs are registered.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_W0   = 3'd1,
      ST_R0W1 = 3'd2,
      ST_R1   = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam int NUM_WORDS  = 32;
   localparam int WORD_BYTES = 8;
   localparam int WORD_IDX_W = $clog2(NUM_WORDS);
   localparam int BYTE_SHIFT = $clog2(WORD_BYTES);

   localparam logic [63:0] DEFAULT_PATTERN = 64'hAAAA_AAAA_AAAA_AAAA;

   // Error counter increment that sticks at all-ones.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/data_mem_bist_if.sv
// rtl/data_mem_bist_if.sv - memory-side bus between the BIST initiator and Data_Memory
//
// Purpose : bundles the Data_Memory control/data pins.
// Signals : MemWrite, MemRead  - cycle type (never both high)
//           Address            - byte address, multiple of the word size
//           WriteData          - data for write cycles, zero otherwise
//           ReadData           - combinational read data from the memory
// Modports: master (BIST side), slave (memory side).
interface data_mem_bist_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 64
);
   logic              MemWrite;
   logic              MemRead;
   logic [ADDR_W-1:0] Address;
   logic [DATA_W-1:0] WriteData;
   logic [DATA_W-1:0] ReadData;

   modport master (
      output MemWrite,
      output MemRead,
      output Address,
      output WriteData,
      input  ReadData
   );

   modport slave (
      input  MemWrite,
      input  MemRead,
      input  Address,
      input  WriteData,
      output ReadData
   );
endinterface

// File: rtl/bist_addr_gen.sv
// rtl/bist_addr_gen.sv - up/down word counter producing the BIST byte address
//
// Purpose : holds the current word index and presents it as a byte address
//           (index x WORD_BYTES).
// Ports   : Clock, Reset_n         - clock, async active-low reset
//           i_load_zero            - load word 0 (highest priority)
//           i_load_last            - load word NUM_WORDS-1
//           i_inc / i_dec          - step up / down by one word
//           o_addr                 - byte address
//           o_last / o_first       - index is at the top / bottom word
module bist_addr_gen
   import data_mem_bist_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic              i_load_zero,
   input  logic              i_load_last,
   input  logic              i_inc,
   input  logic              i_dec,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_last,
   output logic              o_first
);

   localparam logic [WORD_IDX_W-1:0] LAST_IDX = WORD_IDX_W'(NUM_WORDS - 1);

   logic [WORD_IDX_W-1:0] r_word;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_word <= '0;
      end else if (i_load_zero) begin
         r_word <= '0;
      end else if (i_load_last) begin
         r_word <= LAST_IDX;
      end else if (i_inc) begin
         r_word <= r_word + 1'b1;
      end else if (i_dec) begin
         r_word <= r_word - 1'b1;
      end
   end

   // The address is a pure rewiring of the index register, so it is as
   // glitch-free as a registered output.
   assign o_addr  = ADDR_W'(r_word) << BYTE_SHIFT;
   assign o_last  = (r_word == LAST_IDX);
   assign o_first = (r_word == '0);

endmodule

// File: rtl/data_mem_bist.sv
// rtl/data_mem_bist.sv - three-phase march-test initiator for Data_Memory
//
// Purpose : on Start, writes PATTERN everywhere (W0), then per word reads
//           PATTERN and writes ~PATTERN ascending (R0W1), then reads
//           ~PATTERN descending (R1), counting mismatches.
// Ports   : Clock, Reset_n   - clock, async active-low reset
//           Start            - begin a test (honoured in IDLE and DONE only)
//           mem              - memory bus (master modport)
//           Busy, Done, Pass - status; Pass = Done with no mismatches
//           ErrCount         - saturating mismatch count
//           FailAddr/FailData- address and read data of the first mismatch
module data_mem_bist
   import data_mem_bist_pkg::*;
#(
   parameter int              ADDR_W  = 8,
   parameter int              DATA_W  = 64,
   parameter logic [DATA_W-1:0] PATTERN = DEFAULT_PATTERN
) (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic              Start,
   data_mem_bist_if.master   mem,
   output logic              Busy,
   output logic              Done,
   output logic              Pass,
   output logic [7:0]        ErrCount,
   output logic [ADDR_W-1:0] FailAddr,
   output logic [DATA_W-1:0] FailData
);

   state_t              r_state;
   logic                r_mem_write;
   logic                r_mem_read;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_busy;
   logic                r_done;
   logic                r_pass;
   logic [7:0]          r_err_count;
   logic [ADDR_W-1:0]   r_fail_addr;
   logic [DATA_W-1:0]   r_fail_data;

   logic [ADDR_W-1:0]   w_addr;
   logic                w_last;
   logic                w_first;
   logic                w_load_zero;
   logic                w_load_last;
   logic                w_inc;
   logic                w_dec;
   logic                w_sample;
   logic [DATA_W-1:0]   w_expect;
   logic                w_mismatch;
   logic [7:0]          w_err_next;

   bist_addr_gen #(
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .Clock       (Clock),
      .Reset_n     (Reset_n),
      .i_load_zero (w_load_zero),
      .i_load_last (w_load_last),
      .i_inc       (w_inc),
      .i_dec       (w_dec),
      .o_addr      (w_addr),
      .o_last      (w_last),
      .o_first     (w_first)
   );

   // Address stepping follows the cycle currently on the bus: every cycle in
   // W0 and R1, only after the write half of each R0W1 pair.
   always_comb begin
      w_load_zero = 1'b0;
      w_load_last = 1'b0;
      w_inc       = 1'b0;
      w_dec       = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: w_load_zero = Start;
         ST_W0: begin
            if (w_last) w_load_zero = 1'b1;
            else        w_inc       = 1'b1;
         end
         ST_R0W1: begin
            if (r_mem_write) begin
               // R1 starts from the top word, which is where R0W1 ends.
               if (w_last) w_load_last = 1'b1;
               else        w_inc       = 1'b1;
            end
         end
         ST_R1: begin
            if (!w_first) w_dec = 1'b1;
         end
         default: ;
      endcase
   end

   // A read cycle is sampled on the edge that ends it.
   always_comb begin
      w_sample   = ((r_state == ST_R0W1) && r_mem_read) || (r_state == ST_R1);
      w_expect   = (r_state == ST_R1) ? ~PATTERN : PATTERN;
      w_mismatch = w_sample && (mem.ReadData != w_expect);
      w_err_next = w_mismatch ? sat_inc8(r_err_count) : r_err_count;
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state     <= ST_IDLE;
         r_mem_write <= 1'b0;
         r_mem_read  <= 1'b0;
         r_wdata     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_err_count <= '0;
         r_fail_addr <= '0;
         r_fail_data <= '0;
      end else begin
         if (w_mismatch) begin
            r_err_count <= w_err_next;
            if (r_err_count == 8'd0) begin
               r_fail_addr <= w_addr;
               r_fail_data <= mem.ReadData;
            end
         end

         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (Start) begin
                  r_state     <= ST_W0;
                  r_mem_write <= 1'b1;
                  r_mem_read  <= 1'b0;
                  r_wdata     <= PATTERN;
                  r_busy      <= 1'b1;
                  r_done      <= 1'b0;
                  r_pass      <= 1'b0;
                  r_err_count <= '0;
                  r_fail_addr <= '0;
                  r_fail_data <= '0;
               end
            end
            ST_W0: begin
               if (w_last) begin
                  r_state     <= ST_R0W1;
                  r_mem_write <= 1'b0;
                  r_wdata     <= '0;
                  r_mem_read  <= 1'b1;
               end
            end
            ST_R0W1: begin
               if (r_mem_read) begin
                  // Read half done: write the inverse to the same word.
                  r_mem_read  <= 1'b0;
                  r_mem_write <= 1'b1;
                  r_wdata     <= ~PATTERN;
               end else begin
                  r_mem_write <= 1'b0;
                  r_wdata     <= '0;
                  r_mem_read  <= 1'b1;
                  if (w_last) r_state <= ST_R1;
               end
            end
            ST_R1: begin
               if (w_first) begin
                  r_state    <= ST_DONE;
                  r_mem_read <= 1'b0;
                  r_busy     <= 1'b0;
                  r_done     <= 1'b1;
                  // Include a mismatch found on this final sampling edge.
                  r_pass     <= (w_err_next == 8'd0);
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_mem_write <= 1'b0;
               r_mem_read  <= 1'b0;
               r_wdata     <= '0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign mem.MemWrite  = r_mem_write;
   assign mem.MemRead   = r_mem_read;
   assign mem.Address   = w_addr;
   assign mem.WriteData = r_wdata;
   assign Busy          = r_busy;
   assign Done          = r_done;
   assign Pass          = r_pass;
   assign ErrCount      = r_err_count;
   assign FailAddr      = r_fail_addr;
   assign FailData      = r_fail_data;

endmodule

// File: tb/tb_data_mem_bist.sv
// tb/tb_data_mem_bist.sv - directed self-checking bench for data_mem_bist
module tb_data_mem_bist;

   logic        Clock   = 1'b0;
   logic        Reset_n = 1'b0;
   logic        Start   = 1'b0;
   logic        Busy;
   logic        Done;
   logic        Pass;
   logic [7:0]  ErrCount;
   logic [7:0]  FailAddr;
   logic [63:0] FailData;

   int n_vec = 0;
   int n_err = 0;

   data_mem_bist_if #(.ADDR_W(8), .DATA_W(64)) bus ();

   data_mem_bist dut (
      .Clock    (Clock),
      .Reset_n  (Reset_n),
      .Start    (Start),
      .mem      (bus),
      .Busy     (Busy),
      .Done     (Done),
      .Pass     (Pass),
      .ErrCount (ErrCount),
      .FailAddr (FailAddr),
      .FailData (FailData)
   );

   always #5 Clock = ~Clock;

   // Behavioural Data_Memory with optional read-side faults:
   // 1 = LSB of word at 40 stuck at 0, 2 = word at 80 reads all zeros.
   logic [63:0] mem [0:31];
   int          fault_mode = 0;
   logic [63:0] rd_word;

   always @(posedge Clock)
      if (bus.MemWrite) mem[bus.Address[7:3]] <= bus.WriteData;

   always_comb begin
      rd_word = mem[bus.Address[7:3]];
      if (fault_mode == 1 && bus.Address == 8'd40) rd_word[0] = 1'b0;
      if (fault_mode == 2 && bus.Address == 8'd80) rd_word = '0;
      bus.ReadData = bus.MemRead ? rd_word : 64'd0;
   end

   // Protocol monitor: each bus cycle is seen at exactly one falling edge.
   bit         mon_en = 1'b0;
   int         mon_both = 0, mon_misalign = 0, mon_wd_bad = 0, mon_wr = 0, mon_rd = 0;
   logic [7:0] rd_q [$];

   always @(negedge Clock) begin
      if (mon_en) begin
         if (bus.MemWrite && bus.MemRead) mon_both++;
         if (bus.Address[2:0] != 3'd0) mon_misalign++;
         if (!bus.MemWrite && bus.WriteData != 64'd0) mon_wd_bad++;
         if (bus.MemWrite) mon_wr++;
         if (bus.MemRead) begin
            mon_rd++;
            rd_q.push_back(bus.Address);
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " MemWrite"},  64'(bus.MemWrite),  64'd0);
      check({tag, " MemRead"},   64'(bus.MemRead),   64'd0);
      check({tag, " Address"},   64'(bus.Address),   64'd0);
      check({tag, " WriteData"}, bus.WriteData,      64'd0);
      check({tag, " Busy"},      64'(Busy),          64'd0);
      check({tag, " Done"},      64'(Done),          64'd0);
      check({tag, " Pass"},      64'(Pass),          64'd0);
      check({tag, " ErrCount"},  64'(ErrCount),      64'd0);
      check({tag, " FailAddr"},  64'(FailAddr),      64'd0);
      check({tag, " FailData"},  FailData,           64'd0);
   endtask

   // Start is held across exactly one rising edge (E0).
   task automatic pulse_start();
      @(negedge Clock);
      Start = 1'b1;
      @(negedge Clock);
      Start = 1'b0;
   endtask

   // Counts falling edges with Busy high, starting at the current one.
   task automatic wait_done(output int n);
      n = 0;
      while (Busy === 1'b1 && n < 300) begin
         n++;
         @(negedge Clock);
      end
   endtask

   int busy_n;
   int order_bad;

   initial begin
      // Reset state
      repeat (3) @(negedge Clock);
      check_all_zero("reset");
      Reset_n = 1'b1;

      // Clean run with protocol monitor
      fault_mode = 0;
      @(negedge Clock);
      mon_en = 1'b1;
      pulse_start();
      wait_done(busy_n);
      mon_en = 1'b0;
      check("clean busy_cycles", 64'(busy_n),   64'd128);
      check("clean Done",        64'(Done),     64'd1);
      check("clean Pass",        64'(Pass),     64'd1);
      check("clean ErrCount",    64'(ErrCount), 64'd0);
      check("clean FailAddr",    64'(FailAddr), 64'd0);
      check("mon both_high",     64'(mon_both),     64'd0);
      check("mon misaligned",    64'(mon_misalign), 64'd0);
      check("mon wdata_idle",    64'(mon_wd_bad),   64'd0);
      check("mon writes",        64'(mon_wr),       64'd64);
      check("mon reads",         64'(mon_rd),       64'd64);
      order_bad = 0;
      if (rd_q.size() != 64) order_bad = 999;
      else begin
         for (int i = 0; i < 32; i++) begin
            if (rd_q[i] != 8'(8 * i)) order_bad++;
            if (rd_q[32 + i] != 8'(248 - 8 * i)) order_bad++;
         end
      end
      check("mon read_order", 64'(order_bad), 64'd0);

      // Stuck-at-0 LSB at address 40: only the ~PATTERN read sees it
      fault_mode = 1;
      pulse_start();
      wait_done(busy_n);
      check("lsb busy_cycles", 64'(busy_n),   64'd128);
      check("lsb Done",        64'(Done),     64'd1);
      check("lsb ErrCount",    64'(ErrCount), 64'd1);
      check("lsb FailAddr",    64'(FailAddr), 64'd40);
      check("lsb FailData",    FailData,      64'h5555_5555_5555_5554);
      check("lsb Pass",        64'(Pass),     64'd0);

      // Word 80 reads zero: both R0 and R1 miss, first is R0
      fault_mode = 2;
      pulse_start();
      wait_done(busy_n);
      check("zero ErrCount", 64'(ErrCount), 64'd2);
      check("zero FailAddr", 64'(FailAddr), 64'd80);
      check("zero FailData", FailData,      64'd0);
      check("zero Pass",     64'(Pass),     64'd0);

      // Start in DONE clears results and reruns
      fault_mode = 0;
      pulse_start();
      check("restart Done",     64'(Done),     64'd0);
      check("restart Busy",     64'(Busy),     64'd1);
      check("restart ErrCount", 64'(ErrCount), 64'd0);
      check("restart FailAddr", 64'(FailAddr), 64'd0);
      wait_done(busy_n);
      check("restart busy_cycles", 64'(busy_n), 64'd128);
      check("restart Pass",        64'(Pass),   64'd1);

      // Reset 50 cycles into a run
      pulse_start();
      repeat (49) @(negedge Clock);
      check("midrst Busy_before", 64'(Busy), 64'd1);
      Reset_n = 1'b0;
      #1;
      check_all_zero("midrst");
      @(negedge Clock);
      Reset_n = 1'b1;
      pulse_start();
      wait_done(busy_n);
      check("postrst busy_cycles", 64'(busy_n),   64'd128);
      check("postrst Pass",        64'(Pass),     64'd1);
      check("postrst ErrCount",    64'(ErrCount), 64'd0);

      // Start held high throughout the run
      @(negedge Clock);
      Start = 1'b1;
      @(negedge Clock);
      wait_done(busy_n);
      Start = 1'b0;
      check("held busy_cycles", 64'(busy_n), 64'd128);
      check("held Done",        64'(Done),   64'd1);
      @(negedge Clock);
      check("held no_restart Busy", 64'(Busy), 64'd0);
      check("held Done_kept",       64'(Done), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/data_mem_bist.md
# data_mem_bist

Built-in self-test initiator for the Data_Memory block. On a Start pulse it drives Data_Memory's MemWrite/MemRead/Address/WriteData pins through a three-phase march test over all 32 words, checks every ReadData against the expected pattern, and reports pass/fail, an error count and the first failing address and data. It sits beside Data_Memory and is muxed onto the memory's control and data pins in test builds.

## Interface
- ADDR_W, 8, byte-address width
- DATA_W, 64, word width
- NUM_WORDS, 32, words tested; word stride is 8 bytes
- PATTERN, 64'hAAAA_AAAA_AAAA_AAAA, background pattern; its inverse is written in phase 2

- Clock  in  1  single clock; all state updates on its rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  begin a test; sampled only in IDLE and DONE
- MemWrite  out  1  to Data_Memory
- MemRead  out  1  to Data_Memory
- Address  out  ADDR_W  to Data_Memory; always a multiple of 8
- WriteData  out  DATA_W  to Data_Memory
- ReadData  in  DATA_W  from Data_Memory
- Busy  out  1  test in progress
- Done  out  1  test finished; held until the next Start
- Pass  out  1  Done and ErrCount == 0
- ErrCount  out  8  mismatch count, saturating at 255
- FailAddr  out  ADDR_W  address of the first mismatch
- FailData  out  DATA_W  ReadData at the first mismatch

## Operation
- Memory contract:
  - Data_Memory writes WriteData at Address on a rising Clock edge while MemWrite = 1.
  - ReadData is combinational from Address while MemRead = 1.
  - This block samples ReadData on the same edge that ends the read cycle.
- All outputs are registered. MemRead and MemWrite are never high together. WriteData is 0 outside write cycles.
- States:
  - IDLE: Start = 1 -> W0, with addr = 0.
  - W0: write PATTERN, ascending addresses 0..248 in steps of 8. One cycle per address. After 248 -> R0W1 at addr 0.
  - R0W1: per address, one read cycle (expect PATTERN) then one write cycle (~PATTERN). Ascending. After 248 -> R1 at addr 248.
  - R1: read, expect ~PATTERN, descending addresses 248..0. After 0 -> DONE.
  - DONE: Done = 1, Busy = 0, bus idle. Start = 1 -> W0 and clears ErrCount, FailAddr, FailData and Done.
- Compare: on each read-sampling edge, a mismatch increments ErrCount (saturating). If ErrCount was 0, the same edge captures FailAddr and FailData.
- Start is ignored while Busy.
- Reset (any time, including mid-test): state goes to IDLE, and every output goes to 0 (MemWrite, MemRead, Address, WriteData, Busy, Done, Pass, ErrCount, FailAddr, FailData). Memory contents are then undefined; a new Start reruns the full test.

## Timing
- Let E0 be the edge that samples Start = 1. Busy and the first write appear after E0.
- Edge schedule:
  - Writes of W0 occur on E1..E32.
  - R0W1 reads are sampled on odd edges E33..E95; its writes land on even edges E34..E96.
  - R1 samples on E97..E128.
- Done and Pass become valid after E128. Total latency is 128 cycles.
- Address advances every cycle in W0 and R1, and every second cycle in R0W1.
- Address wrap (248 -> 0) never occurs; the phase change happens instead.

## Structure
- Package data_mem_bist_pkg holds:
  - the state enum (IDLE, W0, R0W1, R1, DONE);
  - NUM_WORDS, WORD_BYTES = 8 and the default PATTERN.
- Sub-module bist_addr_gen: an up/down word counter with load-0, load-last and a terminal-count flag, emitting the byte address (word index × 8).
- The top level holds the FSM, the compare logic and the result registers.

## Test plan
- Clean run, behavioural memory:
  - pulse Start -> Busy for 128 cycles;
  - Done = 1, Pass = 1, ErrCount = 0, FailAddr = 0.
- Stuck-at-0 on the LSB of the word at address 40:
  - ErrCount = 1, FailAddr = 40, FailData = 64'h5555_5555_5555_5554, Pass = 0.
- Word at address 80 stuck at all zeros:
  - ErrCount = 2 (R0 and R1), FailAddr = 80, FailData = 0.
- Reset_n low at cycle 50 after Start:
  - all outputs 0 immediately;
  - after release, Start -> clean 128-cycle pass.
- Start held high during Busy -> no restart, still Done at E128. Start in DONE -> Done drops, new run, ErrCount cleared.
- Protocol monitor over a full run:
  - MemRead & MemWrite never both 1;
  - Address % 8 == 0;
  - R1 address order is 248, 240, …, 0;
  - exactly 64 writes and 64 reads.
